// File: rtl/gpio_bus_pkg.sv
// Shared types and constants for the GPIO/UART peripheral-port arbiter.
package gpio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [2:0] EXEC_STATE = 3'd3;

  typedef struct packed {
    logic lb;
    logic lbu;
    logic lh;
    logic lhu;
    logic lw;
    logic sb;
    logic sh;
    logic sw;
  } size_strb_t;

endpackage

// File: rtl/gpio_size_decode.sv
// Maps {we, size, unsigned} onto the one-hot peripheral access strobes.
module gpio_size_decode
  import gpio_bus_pkg::*;
(
  input  logic       i_we,
  input  logic [1:0] i_size,
  input  logic       i_unsigned,
  output size_strb_t o_strb,
  output logic       o_legal
);

  always_comb begin
    o_strb  = '0;
    o_legal = (i_size != SZ_ILLEGAL);
    case (i_size)
      SZ_BYTE: begin
        if (i_we)            o_strb.sb  = 1'b1;
        else if (i_unsigned) o_strb.lbu = 1'b1;
        else                 o_strb.lb  = 1'b1;
      end
      SZ_HALF: begin
        if (i_we)            o_strb.sh  = 1'b1;
        else if (i_unsigned) o_strb.lhu = 1'b1;
        else                 o_strb.lh  = 1'b1;
      end
      SZ_WORD: begin
        if (i_we) o_strb.sw = 1'b1;
        else      o_strb.lw = 1'b1;
      end
      default: o_strb = '0;
    endcase
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the GPIO/UART peripheral port.
// Define ARB_LOCK_EN to let a master's lock input keep priority across transactions.
module gpio_bus_arbiter
  import gpio_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RESET_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic              m0_unsigned,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic              m1_unsigned,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_done,
  output logic              m1_done,
  output logic [DATA_W-1:0] rdata,
  output logic [2:0]        per_state,
  output logic              per_enabled,
  output logic              per_load_enable,
  output logic              per_store_enable,
  output logic              per_is_lb,
  output logic              per_is_lbu,
  output logic              per_is_lh,
  output logic              per_is_lhu,
  output logic              per_is_lw,
  output logic              per_is_sb,
  output logic              per_is_sh,
  output logic              per_is_sw,
  output logic [ADDR_W-1:0] per_address,
  output logic [DATA_W-1:0] per_data_in,
  input  logic [DATA_W-1:0] per_data_out
);

  state_t            r_state;
  logic              r_ptr;
  logic              r_owner;
  logic              r_load_ok;
  logic              r_m0_gnt, r_m1_gnt;
  logic              r_m0_done, r_m1_done;
  logic [DATA_W-1:0] r_rdata;
  logic [2:0]        r_per_state;
  logic              r_per_enabled, r_load_en, r_store_en;
  size_strb_t        r_strb;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_any, w_win;
  logic              w_we, w_unsigned, w_legal;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  size_strb_t        w_strb;
  logic              w_ptr_next;

  // Pointer master wins only when both request; a sole requester always wins.
  assign w_any      = m0_req | m1_req;
  assign w_win      = (m0_req & m1_req) ? r_ptr : m1_req;
  assign w_we       = w_win ? m1_we       : m0_we;
  assign w_size     = w_win ? m1_size     : m0_size;
  assign w_unsigned = w_win ? m1_unsigned : m0_unsigned;
  assign w_addr     = w_win ? m1_addr     : m0_addr;
  assign w_wdata    = w_win ? m1_wdata    : m0_wdata;

  gpio_size_decode u_size_decode (
    .i_we       (w_we),
    .i_size     (w_size),
    .i_unsigned (w_unsigned),
    .o_strb     (w_strb),
    .o_legal    (w_legal)
  );

`ifdef ARB_LOCK_EN
  logic w_owner_lock;
  assign w_owner_lock = r_owner ? m1_lock : m0_lock;
  assign w_ptr_next   = w_owner_lock ? r_owner : ~r_owner;
`else
  logic w_unused_lock;
  assign w_unused_lock = m0_lock ^ m1_lock;
  assign w_ptr_next    = ~r_owner;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ptr         <= (RESET_PRIO != 0);
      r_owner       <= 1'b0;
      r_load_ok     <= 1'b0;
      r_m0_gnt      <= 1'b0;
      r_m1_gnt      <= 1'b0;
      r_m0_done     <= 1'b0;
      r_m1_done     <= 1'b0;
      r_rdata       <= '0;
      r_per_state   <= '0;
      r_per_enabled <= 1'b0;
      r_load_en     <= 1'b0;
      r_store_en    <= 1'b0;
      r_strb        <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
    end else begin
      r_m0_done <= 1'b0;
      r_m1_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_m0_gnt <= w_any & ~w_win;
          r_m1_gnt <= w_any & w_win;
          if (w_any) begin
            r_owner       <= w_win;
            r_addr        <= w_addr;
            r_wdata       <= w_wdata;
            r_load_ok     <= w_legal & ~w_we;
            r_strb        <= w_strb;
            r_per_enabled <= w_legal;
            r_per_state   <= w_legal ? EXEC_STATE : 3'd0;
            r_load_en     <= w_legal & ~w_we;
            r_store_en    <= w_legal & w_we;
            r_state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_strb        <= '0;
          r_per_enabled <= 1'b0;
          r_per_state   <= 3'd0;
          r_load_en     <= 1'b0;
          r_store_en    <= 1'b0;
          r_state       <= ST_COMPLETE;
        end
        ST_COMPLETE: begin
          // per_data_out was registered by the peripheral at the end of ACCESS.
          r_m0_done <= ~r_owner;
          r_m1_done <= r_owner;
          r_rdata   <= r_load_ok ? per_data_out : '0;
          r_ptr     <= w_ptr_next;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m0_gnt           = r_m0_gnt;
  assign m1_gnt           = r_m1_gnt;
  assign m0_done          = r_m0_done;
  assign m1_done          = r_m1_done;
  assign rdata            = r_rdata;
  assign per_state        = r_per_state;
  assign per_enabled      = r_per_enabled;
  assign per_load_enable  = r_load_en;
  assign per_store_enable = r_store_en;
  assign per_is_lb        = r_strb.lb;
  assign per_is_lbu       = r_strb.lbu;
  assign per_is_lh        = r_strb.lh;
  assign per_is_lhu       = r_strb.lhu;
  assign per_is_lw        = r_strb.lw;
  assign per_is_sb        = r_strb.sb;
  assign per_is_sh        = r_strb.sh;
  assign per_is_sw        = r_strb.sw;
  assign per_address      = r_addr;
  assign per_data_in      = r_wdata;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed self-checking bench for gpio_bus_arbiter.
module tb_gpio_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_unsigned, m0_lock;
  logic        m1_req, m1_we, m1_unsigned, m1_lock;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_done, m1_done;
  logic [31:0] rdata, per_address, per_data_in, per_data_out;
  logic [2:0]  per_state;
  logic        per_enabled, per_load_enable, per_store_enable;
  logic        per_is_lb, per_is_lbu, per_is_lh, per_is_lhu;
  logic        per_is_lw, per_is_sb, per_is_sh, per_is_sw;
  logic [7:0]  strb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign strb = {per_is_lb, per_is_lbu, per_is_lh, per_is_lhu,
                 per_is_lw, per_is_sb, per_is_sh, per_is_sw};

  gpio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RESET_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_unsigned(m0_unsigned),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_unsigned(m1_unsigned),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .rdata(rdata), .per_state(per_state), .per_enabled(per_enabled),
    .per_load_enable(per_load_enable), .per_store_enable(per_store_enable),
    .per_is_lb(per_is_lb), .per_is_lbu(per_is_lbu), .per_is_lh(per_is_lh),
    .per_is_lhu(per_is_lhu), .per_is_lw(per_is_lw), .per_is_sb(per_is_sb),
    .per_is_sh(per_is_sh), .per_is_sw(per_is_sw),
    .per_address(per_address), .per_data_in(per_data_in), .per_data_out(per_data_out)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit m, input bit req, input bit we, input logic [1:0] sz,
                       input bit uns, input logic [31:0] addr, input logic [31:0] wd);
    if (m) begin
      m1_req = req; m1_we = we; m1_size = sz; m1_unsigned = uns; m1_addr = addr; m1_wdata = wd;
    end else begin
      m0_req = req; m0_we = we; m0_size = sz; m0_unsigned = uns; m0_addr = addr; m0_wdata = wd;
    end
  endtask

  // One isolated transaction from master m; expectations are supplied by the caller.
  task automatic single(input string tag, input bit m, input bit we, input logic [1:0] sz,
                        input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [7:0] exp_strb, input logic [1:0] exp_ldst,
                        input logic [31:0] exp_rdata);
    logic [1:0] onehot;
    onehot = m ? 2'b01 : 2'b10;
    drive(m, 1'b1, we, sz, uns, addr, wd);
    tick;
    chk({tag, ".gnt"},    {30'd0, m0_gnt, m1_gnt}, {30'd0, onehot});
    chk({tag, ".strb"},   {24'd0, strb}, {24'd0, exp_strb});
    chk({tag, ".ldst"},   {30'd0, per_load_enable, per_store_enable}, {30'd0, exp_ldst});
    chk({tag, ".en"},     {31'd0, per_enabled}, {31'd0, (exp_ldst != 2'b00)});
    chk({tag, ".state"},  {29'd0, per_state}, (exp_ldst != 2'b00) ? 32'd3 : 32'd0);
    chk({tag, ".addr"},   per_address, addr);
    chk({tag, ".wdata"},  per_data_in, wd);
    tick;
    chk({tag, ".en_off"}, {28'd0, per_enabled, per_state}, 32'd0);
    chk({tag, ".nodone"}, {30'd0, m0_done, m1_done}, 32'd0);
    tick;
    chk({tag, ".done"},   {30'd0, m0_done, m1_done}, {30'd0, onehot});
    chk({tag, ".rdata"},  rdata, exp_rdata);
    drive(m, 1'b0, we, sz, uns, addr, wd);
    tick;
    chk({tag, ".idle"},   {28'd0, m0_gnt, m1_gnt, m0_done, m1_done}, 32'd0);
  endtask

  // Both masters hold requests; grants must follow exp_order (bit i = master of txn i).
  task automatic stream(input string tag, input int n, input logic [7:0] exp_order);
    bit m;
    logic [1:0] onehot;
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < n; i++) begin
      m = exp_order[i];
      onehot = m ? 2'b01 : 2'b10;
      tick;
      chk({tag, ".gnt"},  {30'd0, m0_gnt, m1_gnt}, {30'd0, onehot});
      chk({tag, ".addr"}, per_address, m ? 32'h20 : 32'h10);
      tick;
      chk({tag, ".hold"}, {30'd0, m0_gnt, m1_gnt}, {30'd0, onehot});
      tick;
      chk({tag, ".done"}, {28'd0, m0_gnt, m1_gnt, m0_done, m1_done}, {28'd0, onehot, onehot});
      chk({tag, ".rdata"}, rdata, 32'h55);
      if (i == n - 1) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
    tick;
    chk({tag, ".end"}, {30'd0, m0_gnt, m1_gnt}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    m0_lock = 1'b0; m1_lock = 1'b0;
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    per_data_out = 32'h0000_00A5;
    tick;
    tick;
    chk("rst.ctrl",  {28'd0, m0_gnt, m1_gnt, m0_done, m1_done}, 32'd0);
    chk("rst.per",   {20'd0, per_state, per_enabled, strb}, 32'd0);
    chk("rst.ldst",  {30'd0, per_load_enable, per_store_enable}, 32'd0);
    chk("rst.addr",  per_address, 32'd0);
    chk("rst.wdata", per_data_in, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    reset = 1'b0;
    tick;

    single("m0_lw", 0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 8'b0000_1000, 2'b10, 32'hA5);
    per_data_out = 32'hDEAD_BEEF;
    single("m1_sb", 1, 1'b1, 2'b00, 1'b0, 32'h2, 32'h1, 8'b0000_0100, 2'b01, 32'h0);

    per_data_out = 32'h0000_0055;
    single("lb",  0, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0,      8'b1000_0000, 2'b10, 32'h55);
    single("lbu", 0, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0,      8'b0100_0000, 2'b10, 32'h55);
    single("lh",  0, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0,      8'b0010_0000, 2'b10, 32'h55);
    single("lhu", 0, 1'b0, 2'b01, 1'b1, 32'h104, 32'h0,      8'b0001_0000, 2'b10, 32'h55);
    single("sh",  0, 1'b1, 2'b01, 1'b0, 32'h106, 32'h1234,   8'b0000_0010, 2'b01, 32'h0);
    single("sw",  0, 1'b1, 2'b10, 1'b1, 32'h108, 32'hCAFE01, 8'b0000_0001, 2'b01, 32'h0);
    single("ill", 0, 1'b0, 2'b11, 1'b0, 32'h10C, 32'h0,      8'b0000_0000, 2'b00, 32'h0);

    // Master 0 was last served, so the pointer sits on master 1 here.
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    tick;
    chk("rst_mid.access", {29'd0, per_state}, 32'd3);
    reset = 1'b1;
    #1;
    chk("rst_mid.ctrl", {28'd0, m0_gnt, m1_gnt, m0_done, m1_done}, 32'd0);
    chk("rst_mid.per",  {20'd0, per_state, per_enabled, strb}, 32'd0);
    chk("rst_mid.addr", per_address, 32'd0);
    m0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_mid.nodone", {30'd0, m0_done, m1_done}, 32'd0);
    end
    reset = 1'b0;
    tick;
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
    tick;
    chk("post_rst.gnt",  {30'd0, m0_gnt, m1_gnt}, 32'h2);
    chk("post_rst.addr", per_address, 32'h40);
    tick;
    tick;
    chk("post_rst.done", {30'd0, m0_done, m1_done}, 32'h2);
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick;

    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h60, 32'h0);
    tick;
    chk("drop.gnt", {30'd0, m0_gnt, m1_gnt}, 32'h1);
    m1_req = 1'b0;
    m1_addr = 32'h99;
    tick;
    chk("drop.addr_latched", per_address, 32'h60);
    chk("drop.gnt_held", {30'd0, m0_gnt, m1_gnt}, 32'h1);
    tick;
    chk("drop.done",  {30'd0, m0_done, m1_done}, 32'h1);
    chk("drop.rdata", rdata, 32'h55);
    tick;
    chk("drop.idle", {30'd0, m0_gnt, m1_gnt}, 32'd0);

    stream("rr", 6, 8'b0010_1010);

    m0_lock = 1'b1;
`ifdef ARB_LOCK_EN
    stream("lock", 3, 8'b0000_0000);
`else
    stream("lock", 3, 8'b0000_0010);
`endif
    m0_lock = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
